// File: rtl/bbf_shared_unit_scheduler_if.sv
// Bundle of requester, shared-unit and response signals for the float-unit scheduler.
// slave is the scheduler side, master is the environment side.
interface bbf_shared_unit_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [4*N_REQ-1:0]  req_op;
    logic [64*N_REQ-1:0] req_a;
    logic [64*N_REQ-1:0] req_b;

    logic                fu_valid;
    logic [3:0]          fu_op;
    logic [63:0]         fu_in1;
    logic [63:0]         fu_in2;
    logic [63:0]         fu_out;

    logic                resp_valid;
    logic                resp_ready;
    logic [63:0]         resp_data;
    logic [ID_W-1:0]     resp_id;
    logic                resp_err;
    logic                busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, fu_out, resp_ready,
        output req_ready, fu_valid, fu_op, fu_in1, fu_in2,
               resp_valid, resp_data, resp_id, resp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, fu_out, resp_ready,
        input  req_ready, fu_valid, fu_op, fu_in1, fu_in2,
               resp_valid, resp_data, resp_id, resp_err, busy
    );
endinterface

// File: rtl/bbf_shared_unit_scheduler.sv
// Round-robin scheduler sharing one pipelined double-precision unit among N_REQ clients,
// with a tag pipeline matching the unit latency and an in-order result FIFO.
module bbf_shared_unit_scheduler #(
    parameter int N_REQ      = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    bbf_shared_unit_scheduler_if.slave    bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            is_cmp;
        logic            err;
    } tag_t;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic             can_issue;
    logic             accept;
    logic             pop;
    logic             fifo_wr;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    head_idx;
    logic [3:0]       sel_op;
    logic             sel_illegal;
    logic             sel_cmp;
    tag_t             new_tag;
    tag_t             tags [LATENCY+1];
    logic [63:0]      wr_data;

    logic [63:0]      data_mem [FIFO_DEPTH];
    logic [ID_W-1:0]  id_mem   [FIFO_DEPTH];
    logic             err_mem  [FIFO_DEPTH];

    // Search starts one past the last winner so every waiting requester gets a turn.
    always_comb begin : arbiter
        int idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    assign can_issue     = outstanding < CW'(FIFO_DEPTH);
    assign bus.req_ready = (can_issue && !reset) ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    assign sel_op      = bus.req_op[int'(grant_id)*4 +: 4];
    assign sel_illegal = sel_op > 4'd9;
    assign sel_cmp     = (sel_op >= 4'd4) && !sel_illegal;

    always_comb begin
        new_tag        = '0;
        new_tag.valid  = accept;
        new_tag.id     = grant_id;
        new_tag.is_cmp = sel_cmp;
        new_tag.err    = sel_illegal;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= ID_W'(N_REQ - 1);
            bus.fu_valid <= 1'b0;
            bus.fu_op  <= '0;
            bus.fu_in1 <= '0;
            bus.fu_in2 <= '0;
        end else if (accept) begin
            rr_ptr       <= grant_id;
            bus.fu_valid <= !sel_illegal;
            bus.fu_op    <= sel_op;
            bus.fu_in1   <= bus.req_a[int'(grant_id)*64 +: 64];
            bus.fu_in2   <= bus.req_b[int'(grant_id)*64 +: 64];
        end else begin
            bus.fu_valid <= 1'b0;
        end
    end

    // Tags never stall: the unit has a fixed latency, and FIFO room was reserved at accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= LATENCY; i++) tags[i] <= '0;
        end else begin
            tags[0] <= new_tag;
            for (int i = 1; i <= LATENCY; i++) tags[i] <= tags[i-1];
        end
    end

    assign fifo_wr = tags[LATENCY].valid;
    assign wr_data = tags[LATENCY].err    ? 64'h7FF8000000000000 :
                     tags[LATENCY].is_cmp ? {63'b0, bus.fu_out[0]} : bus.fu_out;

    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.resp_valid = fifo_count != '0;
    // When empty, show the slot just popped so the response fields hold their last values.
    assign head_idx       = bus.resp_valid ? rd_ptr : rd_ptr - AW'(1);
    assign bus.resp_data  = data_mem[head_idx];
    assign bus.resp_id    = id_mem[head_idx];
    assign bus.resp_err   = err_mem[head_idx];
    assign bus.busy       = outstanding != '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                id_mem[i]   <= '0;
                err_mem[i]  <= 1'b0;
            end
        end else begin
            if (fifo_wr) begin
                data_mem[wr_ptr] <= wr_data;
                id_mem[wr_ptr]   <= tags[LATENCY].id;
                err_mem[wr_ptr]  <= tags[LATENCY].err;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule
